// File: rtl/fp_unit_arbiter.sv
// Shares one single-precision adder and one multiplier between two requesters,
// holding operands stable for SETTLE_CYCLES before capturing the unit result.
module fp_unit_arbiter #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [1:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [1:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp_result,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic [31:0] add_result,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] mul_result,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [1:0]  OP_ADD   = 2'b00;
    localparam logic [1:0]  OP_SUB   = 2'b01;
    localparam logic [1:0]  OP_MUL   = 2'b10;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [3:0]  CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t      state;
    logic        rr;
    logic [3:0]  cnt;
    logic [1:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        id_q;
    logic [31:0] result_q;

    logic        any_req;
    logic        grant_id;
    logic        accept;
    logic [31:0] capture_val;

    // Round-robin pointer only breaks ties; a lone requester always wins.
    always_comb begin
        grant_id = rr;
        if (req0_valid && !req1_valid) begin
            grant_id = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant_id = 1'b1;
        end
    end

    assign any_req    = req0_valid || req1_valid;
    assign accept     = (state == IDLE) && any_req;
    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept && grant_id;

    always_comb begin
        add_a = '0;
        add_b = '0;
        mul_a = '0;
        mul_b = '0;
        if (state == EXEC) begin
            case (op_q)
                OP_ADD: begin
                    add_a = a_q;
                    add_b = b_q;
                end
                OP_SUB: begin
                    add_a = a_q;
                    add_b = {~b_q[31], b_q[30:0]};
                end
                OP_MUL: begin
                    mul_a = a_q;
                    mul_b = b_q;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (op_q)
            OP_ADD, OP_SUB: capture_val = add_result;
            OP_MUL:         capture_val = mul_result;
            default:        capture_val = QNAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr       <= 1'b0;
            cnt      <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= 1'b0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q  <= grant_id ? req1_op : req0_op;
                        a_q   <= grant_id ? req1_a : req0_a;
                        b_q   <= grant_id ? req1_b : req0_b;
                        id_q  <= grant_id;
                        rr    <= ~grant_id;
                        cnt   <= CNT_LOAD;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == 4'd0) begin
                        result_q <= capture_val;
                        state    <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (id_q ? rsp1_ready : rsp0_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rsp0_valid = (state == RESP) && !id_q;
    assign rsp1_valid = (state == RESP) && id_q;
    assign rsp_result = result_q;
    assign busy       = (state != IDLE);

    settle_range: assert property (@(posedge clk) (SETTLE_CYCLES >= 1) && (SETTLE_CYCLES <= 15));

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Bench for fp_unit_arbiter: stand-in float units, directed vectors, corner
// sequences and random operations checked against a behavioural model.
module tb_fp_unit_arbiter;

    localparam int SETTLE = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp_result;
    logic [31:0] add_a, add_b, add_result, mul_a, mul_b, mul_result;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        id;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[5];

    fp_unit_arbiter #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result),
        .add_a(add_a), .add_b(add_b), .add_result(add_result),
        .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Exact for zero and normal values, which is all the bench ever feeds in.
    function automatic real sp_to_real(input logic [31:0] b);
        logic [10:0] e;
        if (b[30:0] == 31'd0) return 0.0;
        e = {3'b000, b[30:23]} + 11'd896;
        return $bitstoreal({b[31], e, b[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] real_to_sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return 32'd0;
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] int_to_sp(input int n);
        return real_to_sp(real'(n));
    endfunction

    assign add_result = real_to_sp(sp_to_real(add_a) + sp_to_real(add_b));
    assign mul_result = real_to_sp(sp_to_real(mul_a) * sp_to_real(mul_b));

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'b00:   return real_to_sp(sp_to_real(a) + sp_to_real(b));
            2'b01:   return real_to_sp(sp_to_real(a) - sp_to_real(b));
            2'b10:   return real_to_sp(sp_to_real(a) * sp_to_real(b));
            default: return 32'h7FC0_0000;
        endcase
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check_output(name, {31'd0, act}, {31'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_req(input logic id, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; req0_valid = 1'b0;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; req1_valid = 1'b0;
        end
    endtask

    task automatic apply_stimulus(input logic id, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        drive_req(id, op, a, b);
        #1;
        check_bit("granted req_ready", id ? req1_ready : req0_ready, 1'b1);
        check_bit("other req_ready", id ? req0_ready : req1_ready, 1'b0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_op = 2'($urandom_range(0, 3));
        req1_op = 2'($urandom_range(0, 3));
        req0_a = $urandom; req0_b = $urandom;
        req1_a = $urandom; req1_b = $urandom;
    endtask

    task automatic await_rsp(input logic id, input logic [1:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp);
        logic [31:0] e_add_a, e_add_b, e_mul_a, e_mul_b;
        int k;
        e_add_a = (op == 2'b00 || op == 2'b01) ? a : 32'd0;
        e_add_b = (op == 2'b00) ? b : (op == 2'b01) ? {~b[31], b[30:0]} : 32'd0;
        e_mul_a = (op == 2'b10) ? a : 32'd0;
        e_mul_b = (op == 2'b10) ? b : 32'd0;
        k = 0;
        while (k < 20 && !(id ? rsp1_valid : rsp0_valid)) begin
            check_bit("busy in exec", busy, 1'b1);
            check_output("add_a in exec", add_a, e_add_a);
            check_output("add_b in exec", add_b, e_add_b);
            check_output("mul_a in exec", mul_a, e_mul_a);
            check_output("mul_b in exec", mul_b, e_mul_b);
            check_bit("other rsp_valid in exec", id ? rsp0_valid : rsp1_valid, 1'b0);
            tick();
            k++;
        end
        check_output("latency", 32'(k), 32'(SETTLE));
        check_bit("own rsp_valid", id ? rsp1_valid : rsp0_valid, 1'b1);
        check_bit("other rsp_valid", id ? rsp0_valid : rsp1_valid, 1'b0);
        check_output("rsp_result", rsp_result, exp);
    endtask

    task automatic drain(input logic id, input int hold, input logic [31:0] exp);
        for (int h = 0; h < hold; h++) begin
            #1;
            check_bit("rsp_valid held", id ? rsp1_valid : rsp0_valid, 1'b1);
            check_output("rsp_result held", rsp_result, exp);
            check_bit("req0_ready while busy", req0_ready, 1'b0);
            check_bit("req1_ready while busy", req1_ready, 1'b0);
            tick();
        end
        if (id) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        #1;
        check_bit("rsp_valid at completion", id ? rsp1_valid : rsp0_valid, 1'b1);
        check_bit("busy at completion", busy, 1'b1);
        tick();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        check_bit("busy after completion", busy, 1'b0);
        check_bit("rsp_valid after completion", id ? rsp1_valid : rsp0_valid, 1'b0);
    endtask

    task automatic run_vec(input vec_t v, input int hold);
        apply_stimulus(v.id, v.op, v.a, v.b);
        await_rsp(v.id, v.op, v.a, v.b, v.exp);
        drain(v.id, hold, v.exp);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int acc[$];
        vec_t rv;
        int hold;

        vecs[0] = '{id: 1'b0, op: 2'b00, a: 32'h3F80_0000, b: 32'h4000_0000, exp: 32'h4040_0000};
        vecs[1] = '{id: 1'b1, op: 2'b01, a: 32'h4040_0000, b: 32'h3F80_0000, exp: 32'h4000_0000};
        vecs[2] = '{id: 1'b1, op: 2'b10, a: 32'h4000_0000, b: 32'h4040_0000, exp: 32'h40C0_0000};
        vecs[3] = '{id: 1'b0, op: 2'b11, a: 32'h1234_5678, b: 32'h9ABC_DEF0, exp: 32'h7FC0_0000};
        vecs[4] = '{id: 1'b0, op: 2'b01, a: 32'h3F80_0000, b: 32'h4040_0000, exp: 32'hC000_0000};

        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = 2'b00; req1_op = 2'b00;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        repeat (3) tick();

        check_bit("reset req0_ready", req0_ready, 1'b0);
        check_bit("reset req1_ready", req1_ready, 1'b0);
        check_bit("reset rsp0_valid", rsp0_valid, 1'b0);
        check_bit("reset rsp1_valid", rsp1_valid, 1'b0);
        check_bit("reset busy", busy, 1'b0);
        check_output("reset rsp_result", rsp_result, 32'd0);
        check_output("reset add_a", add_a, 32'd0);
        check_output("reset mul_b", mul_b, 32'd0);
        rst = 1'b0;

        // Contention straight out of reset: both held valid, order must alternate from req0.
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 32'h3F80_0000; req0_b = 32'h3F80_0000;
        req1_valid = 1'b1; req1_op = 2'b10; req1_a = 32'h4000_0000; req1_b = 32'h4000_0000;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int k = 0; k < 60 && acc.size() < 3; k++) begin
            #1;
            if (req0_valid && req0_ready) acc.push_back(0);
            if (req1_valid && req1_ready) acc.push_back(1);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int k = 0; k < 20 && busy; k++) tick();
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        check_output("contention accept count", 32'(acc.size()), 32'd3);
        if (acc.size() == 3) begin
            check_output("contention first", 32'(acc[0]), 32'd0);
            check_output("contention second", 32'(acc[1]), 32'd1);
            check_output("contention third", 32'(acc[2]), 32'd0);
        end
        check_bit("busy after contention", busy, 1'b0);

        foreach (vecs[i]) run_vec(vecs[i], 0);

        // Backpressure: req1 waits behind a stalled response, then is taken next IDLE cycle.
        apply_stimulus(1'b0, 2'b00, 32'h3F80_0000, 32'h4040_0000);
        await_rsp(1'b0, 2'b00, 32'h3F80_0000, 32'h4040_0000, 32'h4080_0000);
        drive_req(1'b1, 2'b10, 32'h4000_0000, 32'h4000_0000);
        drain(1'b0, 5, 32'h4080_0000);
        #1;
        check_bit("req1_ready after backpressure", req1_ready, 1'b1);
        tick();
        req1_valid = 1'b0;
        await_rsp(1'b1, 2'b10, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000);
        drain(1'b1, 0, 32'h4080_0000);

        // Reset in the first EXEC cycle drops the operation and clears rr.
        apply_stimulus(1'b0, 2'b00, 32'h3F80_0000, 32'h4000_0000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_bit("busy after mid-exec reset", busy, 1'b0);
        check_output("add_a after mid-exec reset", add_a, 32'd0);
        for (int k = 0; k < 4; k++) begin
            check_bit("no rsp0 after reset", rsp0_valid, 1'b0);
            check_bit("no rsp1 after reset", rsp1_valid, 1'b0);
            tick();
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check_bit("rr cleared req0_ready", req0_ready, 1'b1);
        check_bit("rr cleared req1_ready", req1_ready, 1'b0);
        req1_valid = 1'b0;
        run_vec('{id: 1'b0, op: 2'b00, a: 32'h4000_0000, b: 32'h4040_0000, exp: 32'h40A0_0000}, 0);

        for (int i = 0; i < 30; i++) begin
            rv.id  = 1'($urandom_range(0, 1));
            rv.op  = 2'($urandom_range(0, 3));
            rv.a   = int_to_sp(int'($urandom_range(0, 1000)));
            rv.b   = int_to_sp(int'($urandom_range(0, 1000)));
            rv.exp = ref_result(rv.op, rv.a, rv.b);
            hold   = int'($urandom_range(0, 3));
            run_vec(rv, hold);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
